// File: rtl/axi_r_return_router_if.sv
// axi_r_return_router_if: R-channel bundle between six read slaves, the master port and the read arbiter
interface axi_r_return_router_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
);
    logic [5:0]          grant;
    logic [5:0]          RVALID_S;
    logic [5:0]          RREADY_S;
    logic [6*ID_W-1:0]   RID_S;
    logic [6*DATA_W-1:0] RDATA_S;
    logic [11:0]         RRESP_S;
    logic [5:0]          RLAST_S;
    logic                RVALID_M;
    logic                RREADY_M;
    logic [ID_W-1:0]     RID_M;
    logic [DATA_W-1:0]   RDATA_M;
    logic [1:0]          RRESP_M;
    logic                RLAST_M;
    logic [5:0]          fin;
    logic [5:0]          last;
    logic [5:0]          round;
    logic [7:0]          beat_cnt;
    logic                grant_err;

    modport slave (
        input  grant, RVALID_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RREADY_M,
        output RREADY_S, RVALID_M, RID_M, RDATA_M, RRESP_M, RLAST_M,
        output fin, last, round, beat_cnt, grant_err
    );

    modport master (
        output grant, RVALID_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RREADY_M,
        input  RREADY_S, RVALID_M, RID_M, RDATA_M, RRESP_M, RLAST_M,
        input  fin, last, round, beat_cnt, grant_err
    );
endinterface

// File: rtl/axi_r_return_router.sv
// axi_r_return_router: grant-gated R return path from six slaves through a 2-entry skid FIFO to the master
module axi_r_return_router #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
) (
    input logic                  ACLK,
    input logic                  ARESETn,
    axi_r_return_router_if.slave bus
);
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    beat_t      mem [2];
    beat_t      sel;
    logic [1:0] count;
    logic       wr_ptr, rd_ptr, live, legal, acc, pop;
    logic [5:0] round_q;
    logic [7:0] beat_q;
    logic       err_q;

    // live holds every RREADY_S low until the first edge after reset
    assign legal        = $onehot(bus.grant);
    assign bus.RREADY_S = (live && legal && count != 2'd2) ? bus.grant : 6'b0;
    assign bus.fin      = bus.RVALID_S & bus.RREADY_S;
    assign bus.last     = bus.fin & bus.RLAST_S;
    assign acc          = |bus.fin;
    assign bus.RVALID_M = count != 2'd0;
    assign pop          = bus.RVALID_M & bus.RREADY_M;

    assign bus.RID_M     = mem[rd_ptr].id;
    assign bus.RDATA_M   = mem[rd_ptr].data;
    assign bus.RRESP_M   = mem[rd_ptr].resp;
    assign bus.RLAST_M   = mem[rd_ptr].last;
    assign bus.round     = round_q;
    assign bus.beat_cnt  = beat_q;
    assign bus.grant_err = err_q;

    always_comb begin
        sel = '0;
        for (int i = 0; i < 6; i++)
            if (bus.grant[i])
                sel = {bus.RID_S[i*ID_W +: ID_W], bus.RDATA_S[i*DATA_W +: DATA_W],
                       bus.RRESP_S[2*i +: 2], bus.RLAST_S[i]};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            live    <= 1'b0;
            round_q <= 6'b000001;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            live  <= 1'b1;
            count <= count + {1'b0, acc} - {1'b0, pop};
            if (acc) begin
                mem[wr_ptr] <= sel;
                wr_ptr      <= ~wr_ptr;
                beat_q      <= sel.last ? 8'd0 : beat_q + 8'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (legal)
                round_q <= bus.grant;
            else
                err_q <= 1'b1;
        end
    end
endmodule

// File: doc/axi_r_return_router.md
# axi_r_return_router

R-channel return path between the six read-side slave ports and the master port of the AXI interconnect. Uses the one-hot read-ownership grant from the round-robin read arbiter. Accepts beats only from the granted slave into a 2-entry skid FIFO and replays them to the master in order. Returns per-slave beat-accept pulses and the registered owner vector that the arbiter consumes as `fin`/`RLAST` and `round`.

## Interface
- `ID_W`, 8: RID width on both sides; passed through unchanged.
- `DATA_W`, 32: RDATA width.
- `ACLK`  in  1  clock; all state changes on the rising edge.
- `ARESETn`  in  1  reset; asynchronous, active-low.
- `grant`  in  6  one-hot owner from the read arbiter; bit i selects slave i (bit 5 is the default slave).
- `RVALID_S`  in  6  per-slave RVALID.
- `RREADY_S`  out  6  per-slave RREADY.
- `RID_S`  in  6*ID_W  per-slave RID; slave i occupies bits [i*ID_W +: ID_W].
- `RDATA_S`  in  6*DATA_W  per-slave RDATA, same packing.
- `RRESP_S`  in  12  per-slave RRESP, 2 bits each.
- `RLAST_S`  in  6  per-slave RLAST.
- `RVALID_M`  out  1  master-side RVALID.
- `RREADY_M`  in  1  master-side RREADY.
- `RID_M`, `RDATA_M`, `RRESP_M`, `RLAST_M`  out  ID_W/DATA_W/2/1  head-of-FIFO payload.
- `fin`  out  6  bit i high when a slave-i beat is accepted this cycle. Combinational.
- `last`  out  6  `fin[i] & RLAST_S[i]`. Combinational.
- `round`  out  6  registered owner vector fed back to the arbiter.
- `beat_cnt`  out  8  beats accepted in the current burst.
- `grant_err`  out  1  sticky flag for a grant value that is not one-hot.

## Operation
- Grant legality: `grant` is legal when exactly one bit is set. If it is illegal (zero or multiple bits):
  - all `RREADY_S` are 0;
  - `grant_err` sets and stays set until reset.
- Slave side:
  - `RREADY_S[i] = grant[i] & legal & (count < 2)`.
  - Non-granted slaves always see `RREADY_S = 0`, and their `RVALID_S` is ignored.
- Accept: `acc = |(RVALID_S & RREADY_S)`. On `acc`:
  - the selected {RID, RDATA, RRESP, RLAST} is written at the FIFO write pointer;
  - the write pointer toggles.
- Master side:
  - `RVALID_M = (count != 0)`; the payload comes from the read-pointer entry.
  - On `RVALID_M & RREADY_M`, the read pointer toggles.
- FIFO `count` (0..2):
  - +1 on accept only;
  - -1 on pop only;
  - unchanged on simultaneous accept and pop.
  - Simultaneous accept and pop at count 2 cannot occur, because RREADY_S is 0 when full.
- Payload and `RVALID_M` are stable while `RVALID_M & !RREADY_M`.
- `beat_cnt`:
  - increments on `acc`;
  - clears to 0 on an accept with RLAST;
  - wraps 255 -> 0 with no flag.
- `round`:
  - loads `grant` on every cycle where `grant` is legal;
  - holds its value otherwise.
- Ordering: beats leave in acceptance order, even across an owner change while the FIFO still holds the previous owner's tail.
- The block does not check RID against the owner.

## Timing
- Reset values:
  - `RREADY_S = 0` (count is 0 but grant is gated until the first edge; combinational from reset state);
  - `RVALID_M = 0`, `count = 0`, both pointers 0;
  - `beat_cnt = 0`, `grant_err = 0`, `round = 6'b000001`;
  - payload registers 0.
- Latency: a beat accepted at edge N appears on `RVALID_M` after edge N (one cycle). No combinational path from `RVALID_S` to `RVALID_M`.
- Throughput: 1 beat/cycle sustained while `RREADY_M` is held high.
- Backpressure: with `RREADY_M` low, at most 2 beats are taken, then `RREADY_S` drops combinationally from `count`.
- `fin` and `last` are valid in the accept cycle. The arbiter samples them at that edge, so the new `grant` takes effect the next cycle.
- Reset asserted mid-burst:
  - all state clears immediately;
  - buffered beats are discarded;
  - `RVALID_M` is 0 while `ARESETn` is low.

## Test plan
- Single beat: grant=000001, S0 sends RID=8'h12, RDATA=32'hDEAD_BEEF, RLAST=1, RREADY_M=1 -> fin=000001 and last=000001 in the same cycle; RVALID_M with that payload one cycle later; beat_cnt returns to 0.
- 4-beat burst from S1 with RREADY_M low for 3 cycles -> exactly 2 beats accepted, RREADY_S[1] low while full, then all 4 delivered in order D0..D3 with RLAST only on D3.
- Owner switch: S2 finishes a burst (RLAST) while the FIFO holds 1 beat; the next cycle grant=001000 and S3 sends -> master sees S2's tail, then S3's beats; round follows grant.
- Non-granted slave: grant=000001 while S4 holds RVALID=1 for 10 cycles -> RREADY_S[4]=0, fin[4]=0, nothing enqueued.
- Illegal grant 000011 for 1 cycle -> RREADY_S=0, grant_err=1 and stays set, round unchanged.
- ARESETn pulsed low with 2 beats buffered -> RVALID_M=0 and count=0 immediately; round=000001, beat_cnt=0 after release.
